score_board_bcd: RTL and testbench
==================================

Name: score_board_bcd

Overview:
- Parametrised BCD score keeper for the game datapath; successor to the fixed 5-digit scoreboard.
- Adds configurable point values, a ship-hit penalty, a bonus event, edge-qualified events, saturation and floor clamping, and a frame-synchronised high-score register.
- Sits between the collision detectors and the digit/sprite renderers.
- All digits are exposed as packed BCD nibbles.

Parameters:
- DIGITS, 5: number of BCD digits in score and high score (1..8).
- ALIEN_PTS, 10: points added per alien-missile collision (integer, < 10^DIGITS).
- SHIP_PENALTY, 50: points subtracted per ship-missile collision (integer, < 10^DIGITS).
- BONUS_PTS, 100: points added per bonus event (integer, < 10^DIGITS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- collision_aliens_missile  in  1  alien hit; level, may stay high for several cycles.
- collision_ship_missile  in  1  ship hit; level, may stay high for several cycles.
- bonus_hit  in  1  bonus target hit; level.
- new_game  in  1  clears score only; 1-cycle pulse or level.
- startOfFrame  in  1  1-cycle pulse per video frame.
- score_bcd  out  4*DIGITS  current score; nibble k is digit 10^k.
- hiscore_bcd  out  4*DIGITS  best score since reset.
- new_high  out  1  high when score_bcd > hiscore_bcd at the last startOfFrame.
- saturated  out  1  sticky; set when an add would exceed 10^DIGITS-1.

Behaviour:
- Reset (reset=1 at posedge clk): all outputs and internal state go to 0, including the edge-detect history registers. Reset overrides every other input in the same cycle.
- Edge qualification:
  - Each event input has a previous-sample flop.
  - An event fires on the cycle where input=1 and prev=0.
  - A level held N cycles counts once.
  - An input already high when reset deasserts fires on the first cycle after reset, because prev is 0.
- Latency: score_bcd reflects a fired event on the clock edge that detects it. Input high at edge n (prev 0) means score updated after edge n.
- Delta per cycle:
  - add = ALIEN_PTS·a + BONUS_PTS·b; sub = SHIP_PENALTY·s (a, b, s are the fired flags).
  - Apply next = score + add - sub as one operation. No ordering between simultaneous events.
- Arithmetic: all arithmetic is in BCD, in a single combinational stage.
  - Digit add is carry-propagating with a +6 correction when a digit exceeds 9.
  - Subtraction uses 9's-complement BCD.
  - Parameters are converted to BCD constants at elaboration.
- Clamping:
  - If the true result exceeds 10^DIGITS-1: score becomes all 9s and saturated is set to 1.
  - If the true result is below 0: score becomes 0 and saturated is unchanged.
  - Saturation and floor compare the full net result, not partial sums.
- saturated is cleared only by reset or new_game.
- new_game:
  - score_bcd and saturated go to 0 the next edge.
  - Events fired in the same cycle are discarded.
  - hiscore_bcd is retained.
- startOfFrame: if score_bcd > hiscore_bcd (magnitude compare on the registered score), then hiscore_bcd <= score_bcd and new_high <= 1; else new_high <= 0.
- Comparison uses the score value before any event in the same cycle; the high score lags score by up to one frame.
- Simultaneous new_game and startOfFrame: the high-score compare/update uses the pre-clear score, then the score clears.
- Invalid BCD nibbles cannot arise internally. No input path loads arbitrary digits.
- No handshake; all inputs are synchronous to clk.

Test Plan:
- Reset, then hold collision_aliens_missile high for 4 cycles -> score_bcd = 0x00010 after 1 edge and stays 0x00010; a second rising edge -> 0x00020.
- Score 0x00090, alien hit -> 0x00100 (carry across two digits); score 0x09990 plus bonus -> 0x10090.
- Score 0x00030, ship hit -> 0x00000, saturated stays 0; score 0x00080, alien and ship fire in the same cycle -> 0x00040.
- Score 0x99950, bonus -> 0x99999 and saturated=1; further alien hit -> still 0x99999; new_game -> score 0, saturated 0.
- Score 0x00120, hiscore 0x00100, startOfFrame -> hiscore 0x00120, new_high=1; next startOfFrame unchanged -> new_high=0; new_game + startOfFrame same cycle -> hiscore 0x00120 and score 0.
- Assert reset mid-run with the alien input held high -> all outputs 0 the next edge; deassert with the input still high -> score 0x00010 one edge later.

Source files
------------

// File: rtl/score_board_bcd_if.sv
// Event and score bundle between the collision detectors, the score keeper and the renderers.
interface score_board_bcd_if #(
  parameter int unsigned DIGITS = 5
);
  logic                  collision_aliens_missile;
  logic                  collision_ship_missile;
  logic                  bonus_hit;
  logic                  new_game;
  logic                  startOfFrame;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   hiscore_bcd;
  logic                  new_high;
  logic                  saturated;

  modport master (
    output collision_aliens_missile, collision_ship_missile, bonus_hit, new_game, startOfFrame,
    input  score_bcd, hiscore_bcd, new_high, saturated
  );

  modport slave (
    input  collision_aliens_missile, collision_ship_missile, bonus_hit, new_game, startOfFrame,
    output score_bcd, hiscore_bcd, new_high, saturated
  );
endinterface

// File: rtl/score_board_bcd.sv
// BCD score keeper: edge-qualified events, single-stage BCD add/subtract with clamping,
// and a high-score register updated on frame start.
module score_board_bcd #(
  parameter int unsigned DIGITS       = 5,
  parameter int unsigned ALIEN_PTS    = 10,
  parameter int unsigned SHIP_PENALTY = 50,
  parameter int unsigned BONUS_PTS    = 100
) (
  input  logic               clk,
  input  logic               reset,
  score_board_bcd_if.slave   bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned WX = 4 * (DIGITS + 1);

  function automatic logic [WX-1:0] to_bcd(input int unsigned v);
    logic [WX-1:0] r;
    int unsigned   x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < DIGITS + 1; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x           = x / 10;
    end
    return r;
  endfunction

  function automatic logic [WX:0] bcd_add(input logic [WX-1:0] a, input logic [WX-1:0] b,
                                          input logic cin);
    logic [WX-1:0] s;
    logic          c;
    logic [4:0]    t;
    s = '0;
    c = cin;
    for (int unsigned i = 0; i < DIGITS + 1; i++) begin
      t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (t > 5'd9) begin
        t = t + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i +: 4] = t[3:0];
    end
    return {c, s};
  endfunction

  function automatic logic [WX-1:0] nines(input logic [WX-1:0] x);
    logic [WX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DIGITS + 1; i++) r[4*i +: 4] = 4'd9 - x[4*i +: 4];
    return r;
  endfunction

  localparam logic [WX-1:0] ALIEN_BCD = to_bcd(ALIEN_PTS);
  localparam logic [WX-1:0] SHIP_BCD  = to_bcd(SHIP_PENALTY);
  localparam logic [WX-1:0] BONUS_BCD = to_bcd(BONUS_PTS);

  logic          a_prev_q, s_prev_q, b_prev_q;
  logic [W-1:0]  score_q, score_d;
  logic [W-1:0]  hiscore_q;
  logic          new_high_q, sat_q, sat_set_d;
  logic          fire_a, fire_s, fire_b;
  logic [WX-1:0] sum1, sum2;
  logic [WX:0]   diff;

  assign fire_a = bus.collision_aliens_missile & ~a_prev_q;
  assign fire_s = bus.collision_ship_missile   & ~s_prev_q;
  assign fire_b = bus.bonus_hit                & ~b_prev_q;

  // One extra digit holds the full net result; adding the 9's complement plus one
  // leaves a carry out exactly when the net is non-negative.
  always_comb begin
    score_d   = score_q;
    sat_set_d = 1'b0;
    sum1 = WX'(bcd_add({4'b0, score_q}, fire_a ? ALIEN_BCD : '0, 1'b0));
    sum2 = WX'(bcd_add(sum1, fire_b ? BONUS_BCD : '0, 1'b0));
    diff = bcd_add(sum2, nines(fire_s ? SHIP_BCD : '0), 1'b1);
    if (!diff[WX]) begin
      score_d = '0;
    end else if (diff[WX-1 -: 4] != 4'd0) begin
      score_d   = {DIGITS{4'h9}};
      sat_set_d = 1'b1;
    end else begin
      score_d = diff[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_prev_q   <= 1'b0;
      s_prev_q   <= 1'b0;
      b_prev_q   <= 1'b0;
      score_q    <= '0;
      hiscore_q  <= '0;
      new_high_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      a_prev_q <= bus.collision_aliens_missile;
      s_prev_q <= bus.collision_ship_missile;
      b_prev_q <= bus.bonus_hit;
      // Valid BCD orders like binary, so a plain compare on the packed nibbles suffices.
      if (bus.startOfFrame) begin
        if (score_q > hiscore_q) begin
          hiscore_q  <= score_q;
          new_high_q <= 1'b1;
        end else begin
          new_high_q <= 1'b0;
        end
      end
      if (bus.new_game) begin
        score_q <= '0;
        sat_q   <= 1'b0;
      end else begin
        score_q <= score_d;
        sat_q   <= sat_q | sat_set_d;
      end
    end
  end

  assign bus.score_bcd   = score_q;
  assign bus.hiscore_bcd = hiscore_q;
  assign bus.new_high    = new_high_q;
  assign bus.saturated   = sat_q;
endmodule

// File: tb/tb_score_board_bcd.sv
// Directed bench for score_board_bcd: integer reference model feeds an expectation queue
// that is popped and compared one edge after each stimulus step.
module tb_score_board_bcd;
  logic clk = 1'b0;
  logic reset;

  score_board_bcd_if #(.DIGITS(5)) bus ();

  score_board_bcd #(
    .DIGITS(5), .ALIEN_PTS(10), .SHIP_PENALTY(50), .BONUS_PTS(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] score;
    logic [19:0] hi;
    logic        nh;
    logic        sat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_score = 0, m_hi = 0;
  bit   m_nh = 0, m_sat = 0, pa = 0, ps = 0, pb = 0;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit a, input bit s, input bit b,
                      input bit ng, input bit sof);
    exp_t e;
    int   net;
    reset = rst;
    bus.collision_aliens_missile = a;
    bus.collision_ship_missile   = s;
    bus.bonus_hit                = b;
    bus.new_game                 = ng;
    bus.startOfFrame             = sof;
    if (rst) begin
      m_score = 0; m_hi = 0; m_nh = 0; m_sat = 0;
      pa = 0; ps = 0; pb = 0;
    end else begin
      net = m_score + ((a && !pa) ? 10 : 0) + ((b && !pb) ? 100 : 0) - ((s && !ps) ? 50 : 0);
      if (sof) begin
        if (m_score > m_hi) begin
          m_hi = m_score;
          m_nh = 1;
        end else begin
          m_nh = 0;
        end
      end
      if (ng) begin
        m_score = 0;
        m_sat   = 0;
      end else if (net > 99999) begin
        m_score = 99999;
        m_sat   = 1;
      end else if (net < 0) begin
        m_score = 0;
      end else begin
        m_score = net;
      end
      pa = a; ps = s; pb = b;
    end
    e.score = to_bcd(m_score);
    e.hi    = to_bcd(m_hi);
    e.nh    = m_nh;
    e.sat   = m_sat;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("score", bus.score_bcd, e.score);
    chk("hiscore", bus.hiscore_bcd, e.hi);
    chk("new_high", {19'b0, bus.new_high}, {19'b0, e.nh});
    chk("saturated", {19'b0, bus.saturated}, {19'b0, e.sat});
  endtask

  task automatic pulse(input bit a, input bit s, input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      step(0, a, s, b, 0, 0);
      step(0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.collision_aliens_missile = 1'b0;
    bus.collision_ship_missile   = 1'b0;
    bus.bonus_hit                = 1'b0;
    bus.new_game                 = 1'b0;
    bus.startOfFrame             = 1'b0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_score", bus.score_bcd, 20'h00000);
    chk("reset_hiscore", bus.hiscore_bcd, 20'h00000);

    // Level held four cycles counts once
    step(0, 1, 0, 0, 0, 0);
    chk("alien_first_edge", bus.score_bcd, 20'h00010);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    chk("alien_level_held", bus.score_bcd, 20'h00010);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("alien_second_edge", bus.score_bcd, 20'h00020);
    step(0, 0, 0, 0, 0, 0);

    // Carry across two digits
    pulse(1, 0, 0, 7);
    chk("score_90", bus.score_bcd, 20'h00090);
    pulse(1, 0, 0, 1);
    chk("carry_100", bus.score_bcd, 20'h00100);

    // 9990 + bonus
    step(0, 0, 0, 0, 1, 0);
    pulse(0, 0, 1, 99);
    pulse(1, 0, 0, 9);
    chk("score_9990", bus.score_bcd, 20'h09990);
    pulse(0, 0, 1, 1);
    chk("bonus_carry_10090", bus.score_bcd, 20'h10090);

    // Floor clamp and simultaneous add/subtract
    step(0, 0, 0, 0, 1, 0);
    pulse(1, 0, 0, 3);
    pulse(0, 1, 0, 1);
    chk("floor_zero", bus.score_bcd, 20'h00000);
    chk("floor_no_sat", {19'b0, bus.saturated}, 20'h0);
    pulse(1, 0, 0, 8);
    pulse(1, 1, 0, 1);
    chk("alien_ship_same_cycle", bus.score_bcd, 20'h00040);

    // Saturation
    step(0, 0, 0, 0, 1, 0);
    pulse(0, 0, 1, 999);
    pulse(1, 0, 0, 5);
    chk("score_99950", bus.score_bcd, 20'h99950);
    pulse(0, 0, 1, 1);
    chk("sat_score", bus.score_bcd, 20'h99999);
    chk("sat_flag", {19'b0, bus.saturated}, 20'h1);
    pulse(1, 0, 0, 1);
    chk("sat_hold", bus.score_bcd, 20'h99999);
    step(0, 1, 0, 0, 1, 0);
    chk("new_game_score", bus.score_bcd, 20'h00000);
    chk("new_game_sat", {19'b0, bus.saturated}, 20'h0);
    step(0, 0, 0, 0, 0, 0);

    // High score tracking
    pulse(1, 0, 0, 10);
    step(0, 0, 0, 0, 0, 1);
    chk("hiscore_100", bus.hiscore_bcd, 20'h00100);
    pulse(1, 0, 0, 2);
    step(0, 0, 0, 0, 0, 1);
    chk("hiscore_120", bus.hiscore_bcd, 20'h00120);
    chk("new_high_set", {19'b0, bus.new_high}, 20'h1);
    step(0, 0, 0, 0, 0, 1);
    chk("new_high_clear", {19'b0, bus.new_high}, 20'h0);
    pulse(1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("ng_sof_hiscore", bus.hiscore_bcd, 20'h00130);
    chk("ng_sof_score", bus.score_bcd, 20'h00000);

    // Reset mid-run with the alien input held high
    pulse(1, 0, 0, 3);
    step(1, 1, 0, 0, 0, 0);
    chk("midreset_score", bus.score_bcd, 20'h00000);
    chk("midreset_hiscore", bus.hiscore_bcd, 20'h00000);
    step(0, 1, 0, 0, 0, 0);
    chk("post_reset_fire", bus.score_bcd, 20'h00010);
    step(0, 1, 0, 0, 0, 0);
    chk("post_reset_hold", bus.score_bcd, 20'h00010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
